// File: rtl/rom_code_verifier.sv
// rom_code_verifier
// Reads the stored access code from a synchronous code ROM (one-cycle read
// latency) and compares it nibble by nibble against digits from the keypad
// front end. The block produces a one-cycle match or mismatch verdict.
// Every attempt consumes all CODE_LEN digits, so the verdict timing does not
// reveal where the first wrong digit was.
//
// Optional feature: define LOCKOUT_EN to build the consecutive-failure counter.
// When the counter reaches MAX_TRIES, locked_o is set and stays set until rst_i.
// Without LOCKOUT_EN, locked_o is tied low and the number of attempts is unlimited.

module rom_code_verifier #(
  parameter int CODE_LEN  = 5,
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 4,
  parameter int MAX_TRIES = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] digit_in_i,
  input  logic              digit_valid_i,
  output logic              digit_ready_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic              busy_o,
  output logic              match_o,
  output logic              mismatch_o,
  output logic              locked_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(CODE_LEN - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic              err_q;
  logic              busy_q;
  logic              ready_q;
  logic              match_q;
  logic              mismatch_q;

  logic              err_d;
  logic              locked_s;
  logic              start_ok_s;

  // Running error flag including the digit currently presented.
  assign err_d      = err_q | (digit_in_i != rom_data_i);
  assign start_ok_s = start_i & ~locked_s;

  // Attempt sequencer: walks ROM addresses and registers all block outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      rom_addr_q <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      match_q    <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      match_q    <= 1'b0;
      mismatch_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_ok_s) begin
            idx_q      <= '0;
            rom_addr_q <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          // The ROM registers rom[idx] at the end of this cycle.
          ready_q <= 1'b1;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (digit_valid_i) begin
            err_q   <= err_d;
            ready_q <= 1'b0;
            if (idx_q == LAST_IDX) begin
              match_q    <= ~err_d;
              mismatch_q <= err_d;
              state_q    <= ST_DONE;
            end else begin
              idx_q      <= idx_q + ADDR_W'(1);
              rom_addr_q <= idx_q + ADDR_W'(1);
              state_q    <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef LOCKOUT_EN
  localparam int CNT_W = (MAX_TRIES < 2) ? 1 : $clog2(MAX_TRIES + 1);

  logic [CNT_W-1:0] fail_cnt_q;
  logic             locked_q;

  // Saturating count of consecutive failures; latch lockout at MAX_TRIES.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fail_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else if (state_q == ST_DONE) begin
      if (err_q) begin
        if (fail_cnt_q < CNT_W'(MAX_TRIES)) begin
          fail_cnt_q <= fail_cnt_q + CNT_W'(1);
        end
        if (fail_cnt_q >= CNT_W'(MAX_TRIES - 1)) begin
          locked_q <= 1'b1;
        end
      end else begin
        fail_cnt_q <= '0;
      end
    end
  end

  assign locked_s = locked_q;
`else
  logic unused_tries_s;
  assign unused_tries_s = (MAX_TRIES == 0);
  assign locked_s       = 1'b0;
`endif

  assign digit_ready_o = ready_q;
  assign rom_addr_o    = rom_addr_q;
  assign busy_o        = busy_q;
  assign match_o       = match_q;
  assign mismatch_o    = mismatch_q;
  assign locked_o      = locked_s;

endmodule
